data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
// - Round-robin arbiter that shares one single-port data RAM among core_count processor cores.
// - Each core issues load/store requests with a req/ack handshake. The arbiter serialises them into
//   the RAM port and returns read data to the winning core.
// - Sits between the Processor_Core AR/DR/mem_write outputs and the data RAM, in place of a multiport RAM.
// PARAMETERS
// - core_count  2   number of requesting cores (>=1)
// - reg_width   12  data word width
// - addr_width  12  data memory address width
// PORTS
// - clk         in   1                      system clock; all logic on rising edge
// - reset       in   1                      synchronous, active-high
// - req         in   core_count             per-core access request; held high until ack
// - we          in   core_count             per-core write enable (1=store, 0=load); valid while req
// - addr        in   addr_width*core_count  packed; core j at [(j+1)*addr_width-1 -: addr_width]
// - wdata       in   reg_width*core_count   packed; core j at [(j+1)*reg_width-1 -: reg_width]
// - ack         out  core_count             one-cycle pulse; access of core j complete
// - rdata       out  reg_width              load data; valid when any ack bit is set
// - mem_addr    out  addr_width             to RAM address
// - mem_wdata   out  reg_width              to RAM data in
// - mem_wren    out  1                      to RAM write enable
// - mem_q       in   reg_width              RAM registered output, 1-cycle read latency
// - busy        out  1                      high in ISSUE or RESP
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, ack=0, rdata=0, mem_addr=0, mem_wdata=0, mem_wren=0, busy=0.
// - All outputs are registered.
// - FSM states: IDLE, ISSUE, RESP.
//   - IDLE: if any req, pick winner g (rule below).
//     - Register mem_addr=addr[g], mem_wdata=wdata[g], mem_wren=we[g] and gnt=g.
//     - Go to ISSUE.
//   - ISSUE: RAM samples the port this cycle. Next edge: mem_wren<=0, go to RESP.
//   - RESP: mem_q is valid. Register ack[gnt]<=1 and rdata<=mem_q (stores also load rdata; a
//     don't-care).
//     - Go to IDLE.
//     - The request of gnt is not eligible in the arbitration cycle that follows its ack.
// - Latency: req seen at edge N -> ack high in cycle N+3. Sustained throughput: one access per 3
//   cycles.
// - Arbitration: rotating priority. Search starts at rr_ptr and increments modulo core_count. The
//   first set req wins.
//   - After a grant, rr_ptr <= (g+1) mod core_count.
//   - Pointer update does not occur when no req is set.
// - Fairness: with all cores requesting continuously, each core is granted once per core_count
//   accesses.
// - Simultaneous events:
//   - req rising on several cores in one cycle resolves by the rotating rule only.
//   - A req arriving while busy waits; there is no queueing beyond the held req level.
// - Protocol: req/we/addr/wdata must stay stable until ack. A req dropped mid-access is ignored and
//   the access still completes with ack.
// - Wrap-around: rr_ptr=core_count-1 wraps to 0. With core_count=1, rr_ptr stays 0.
// - Address: passed through unmodified; no range check. Writes to the same address by two cores
//   land in grant order.
// - Reset mid-operation: FSM aborts to IDLE next edge and mem_wren drops.
//   - A write already sampled by the RAM in ISSUE stays committed.
//   - No ack is issued for the aborted access.
// STRUCTURE
// - Shared header data_mem_arb_defs.vh: state encodings ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_RESP=2'd2.
// - Sub-module rr_priority_pick (combinational).
//   - Inputs: req vector, rr_ptr, blocked-index mask.
//   - Outputs: winner index (clog2 width) and valid.
//   - Reused later for the instruction memory port.
// - Top level: FSM, port registers, unpacking of the packed buses via generate.
// TESTING
// - Reset: hold reset 2 cycles with req=2'b11 -> ack=0, mem_wren=0, busy=0, rr_ptr=0 throughout.
// - Single store then load, core0: store addr=12'h010, wdata=12'hABC.
//   - Store: ack[0] 3 cycles after req.
//   - Load of the same address: rdata=12'hABC with ack[0].
// - Contention: both cores req loads from 12'h010 and 12'h020 (preloaded 12'h111 and 12'h222) in the
//   same cycle.
//   - core0 is acked first with 12'h111.
//   - core1 is acked 3 cycles later with 12'h222.
// - Fairness: both cores req continuously for 8 accesses -> ack order 0,1,0,1,... with no core
//   granted twice in a row.
// - Write collision: core0 writes 12'h555 and core1 writes 12'h777 to 12'h030 simultaneously.
//   - Grant order is core0 then core1.
//   - A subsequent load returns 12'h777.
// - Reset in ISSUE of a core1 store to 12'h040 -> no ack[1]. FSM returns to IDLE and accepts a new
//   req normally.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter_pkg
// Shared definitions for the data-memory arbiter and its helpers.
//   - arb_state_t : FSM encoding (ST_IDLE=0, ST_ISSUE=1, ST_RESP=2)
//   - DEF_*       : default parameter values for the arbiter and its interface
//   - ptr_width() : width of a core index / round-robin pointer (at least 1 bit)
// ----------------------------------------------------------------------------
package data_mem_arbiter_pkg;

  localparam int DEF_CORE_COUNT = 2;
  localparam int DEF_REG_WIDTH  = 12;
  localparam int DEF_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  // A single core still needs a one-bit index so that ports never collapse
  // to zero width.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter_if
// Bundles the per-core request bus and the single RAM port seen by the
// arbiter.
//   Core side : req, we, addr (packed), wdata (packed)  -> arbiter
//               ack, rdata                              <- arbiter
//   RAM side  : mem_addr, mem_wdata, mem_wren           <- arbiter
//               mem_q (registered RAM output)           -> arbiter
//   Status    : busy                                    <- arbiter
// Modports:
//   slave  : the arbiter itself
//   master : the environment (cores plus RAM) around the arbiter
// ----------------------------------------------------------------------------
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int core_count = DEF_CORE_COUNT,
  parameter int reg_width  = DEF_REG_WIDTH,
  parameter int addr_width = DEF_ADDR_WIDTH
);

  logic [core_count-1:0]            req;
  logic [core_count-1:0]            we;
  logic [addr_width*core_count-1:0] addr;
  logic [reg_width*core_count-1:0]  wdata;
  logic [core_count-1:0]            ack;
  logic [reg_width-1:0]             rdata;
  logic [addr_width-1:0]            mem_addr;
  logic [reg_width-1:0]             mem_wdata;
  logic                             mem_wren;
  logic [reg_width-1:0]             mem_q;
  logic                             busy;

  modport slave (
    input  req, we, addr, wdata, mem_q,
    output ack, rdata, mem_addr, mem_wdata, mem_wren, busy
  );

  modport master (
    output req, we, addr, wdata, mem_q,
    input  ack, rdata, mem_addr, mem_wdata, mem_wren, busy
  );

endinterface

// File: rtl/data_mem_arbiter_rr_priority_pick.sv
// ----------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating-priority picker. Starting at rr_ptr and moving
// upward modulo core_count, the first request that is not masked by
// 'blocked' wins. Kept generic so that the instruction-memory port can
// reuse it.
//   req_vec : per-core request levels
//   rr_ptr  : index with highest priority this cycle
//   blocked : per-core mask; a set bit makes that core ineligible
//   winner  : index of the chosen core (0 when valid is low)
//   valid   : at least one eligible request exists
// ----------------------------------------------------------------------------
module rr_priority_pick
  import data_mem_arbiter_pkg::*;
#(
  parameter int core_count = DEF_CORE_COUNT,
  parameter int ptr_w      = ptr_width(DEF_CORE_COUNT)
) (
  input  logic [core_count-1:0] req_vec,
  input  logic [ptr_w-1:0]      rr_ptr,
  input  logic [core_count-1:0] blocked,
  output logic [ptr_w-1:0]      winner,
  output logic                  valid
);

  // One extra bit so rr_ptr + offset cannot overflow before the wrap.
  localparam int sum_w = ptr_w + 1;

  logic [core_count-1:0] eligible_s;
  logic [sum_w-1:0]      sum_s;
  logic [ptr_w-1:0]      idx_s;
  logic                  hit_s;

  assign eligible_s = req_vec & ~blocked;

  // Walk the cores in priority order; the first eligible one latches the win.
  always_comb begin
    winner = {ptr_w{1'b0}};
    valid  = 1'b0;
    sum_s  = {sum_w{1'b0}};
    idx_s  = {ptr_w{1'b0}};
    hit_s  = 1'b0;
    for (int k = 0; k < core_count; k++) begin
      sum_s  = {1'b0, rr_ptr} + sum_w'(k);
      // rr_ptr < core_count and k < core_count, so one subtraction wraps.
      idx_s  = ptr_w'((sum_s >= sum_w'(core_count)) ? (sum_s - sum_w'(core_count)) : sum_s);
      hit_s  = eligible_s[idx_s] & ~valid;
      winner = hit_s ? idx_s : winner;
      valid  = valid | hit_s;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter
// Round-robin arbiter that lets core_count processor cores share one
// single-port data RAM with a 1-cycle registered read.
// Each access takes three cycles: IDLE (arbitrate, register the RAM port),
// ISSUE (RAM samples the port), RESP (RAM output valid, pulse ack).
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; aborts any access without ack
//   bus   : data_mem_arbiter_if.slave
//     req/we/addr/wdata : per-core request, held stable until ack
//     ack               : one-cycle completion pulse for the granted core
//     rdata             : load data, valid while any ack bit is set
//     mem_addr/mem_wdata/mem_wren : RAM port
//     mem_q             : RAM registered output
//     busy              : high while in ISSUE or RESP
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int core_count = DEF_CORE_COUNT,
  parameter int reg_width  = DEF_REG_WIDTH,
  parameter int addr_width = DEF_ADDR_WIDTH
) (
  input logic               clk,
  input logic               reset,
  data_mem_arbiter_if.slave bus
);

  localparam int ptr_w = ptr_width(core_count);

  // Unpacked views of the packed per-core buses.
  logic [addr_width-1:0] addr_s  [core_count];
  logic [reg_width-1:0]  wdata_s [core_count];

  arb_state_t            state_r;
  logic [ptr_w-1:0]      rr_ptr_r;
  logic [ptr_w-1:0]      gnt_r;
  logic [core_count-1:0] block_mask_r;
  logic [core_count-1:0] ack_r;
  logic [reg_width-1:0]  rdata_r;
  logic [addr_width-1:0] mem_addr_r;
  logic [reg_width-1:0]  mem_wdata_r;
  logic                  mem_wren_r;
  logic                  busy_r;

  logic [ptr_w-1:0]      pick_s;
  logic                  pick_valid_s;
  logic [ptr_w-1:0]      next_ptr_s;
  logic [core_count-1:0] gnt_onehot_s;

  generate
    for (genvar j = 0; j < core_count; j++) begin : g_unpack
      assign addr_s[j]       = bus.addr[(j+1)*addr_width-1 -: addr_width];
      assign wdata_s[j]      = bus.wdata[(j+1)*reg_width-1 -: reg_width];
      assign gnt_onehot_s[j] = (gnt_r == ptr_w'(j));
    end
  endgenerate

  rr_priority_pick #(
    .core_count (core_count),
    .ptr_w      (ptr_w)
  ) u_pick (
    .req_vec (bus.req),
    .rr_ptr  (rr_ptr_r),
    .blocked (block_mask_r),
    .winner  (pick_s),
    .valid   (pick_valid_s)
  );

  // Pointer moves just past the winner; the top index wraps to 0 (and with
  // a single core the pointer therefore never leaves 0).
  assign next_ptr_s = (pick_s == ptr_w'(core_count - 1)) ? {ptr_w{1'b0}}
                                                          : pick_s + ptr_w'(1'b1);

  // Access sequencer: arbitration, RAM port registers, response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= {ptr_w{1'b0}};
      gnt_r        <= {ptr_w{1'b0}};
      block_mask_r <= {core_count{1'b0}};
      ack_r        <= {core_count{1'b0}};
      rdata_r      <= {reg_width{1'b0}};
      mem_addr_r   <= {addr_width{1'b0}};
      mem_wdata_r  <= {reg_width{1'b0}};
      mem_wren_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      // ack is a single-cycle pulse; only RESP raises a bit.
      ack_r <= {core_count{1'b0}};
      case (state_r)
        ST_IDLE: begin
          // The just-acked core sits out exactly one arbitration cycle,
          // since it is still holding req while it sees its ack.
          block_mask_r <= {core_count{1'b0}};
          if (pick_valid_s) begin
            mem_addr_r  <= addr_s[pick_s];
            mem_wdata_r <= wdata_s[pick_s];
            mem_wren_r  <= bus.we[pick_s];
            gnt_r       <= pick_s;
            rr_ptr_r    <= next_ptr_s;
            busy_r      <= 1'b1;
            state_r     <= ST_ISSUE;
          end else begin
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // RAM has sampled the port at this edge; stop writing.
          mem_wren_r   <= 1'b0;
          block_mask_r <= {core_count{1'b0}};
          busy_r       <= 1'b1;
          state_r      <= ST_RESP;
        end
        ST_RESP: begin
          // mem_q is valid now; stores capture it too but nobody uses it.
          ack_r[gnt_r] <= 1'b1;
          rdata_r      <= bus.mem_q;
          block_mask_r <= gnt_onehot_s;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          mem_wren_r   <= 1'b0;
          block_mask_r <= {core_count{1'b0}};
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack       = ack_r;
  assign bus.rdata     = rdata_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_wren  = mem_wren_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Two-core bench with a behavioural 4096x12 RAM (1-cycle registered read).
// A table of single-core accesses is followed by hand-written sequences for
// contention, fairness, write collision and reset during ISSUE.
// ----------------------------------------------------------------------------
module tb_data_mem_arbiter;

  logic clk;
  logic reset;

  data_mem_arbiter_if #(.core_count(2), .reg_width(12), .addr_width(12)) bus_if ();

  data_mem_arbiter #(.core_count(2), .reg_width(12), .addr_width(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered output.
  logic [11:0] ram [4096];
  always @(posedge clk) begin
    if (bus_if.mem_wren) ram[bus_if.mem_addr] <= bus_if.mem_wdata;
    bus_if.mem_q <= ram[bus_if.mem_addr];
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int          core;
    logic        we;
    logic [11:0] addr;
    logic [11:0] wdata;
    logic        chk;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One access by a lone core: checks the RAM port in ISSUE, 3-cycle
  // latency, ack bit, optional load data and that ack lasts one cycle.
  task automatic single_access(input string tag, input int c, input logic w,
                               input logic [11:0] a, input logic [11:0] d,
                               input logic chk, input logic [11:0] exp);
    int cyc;
    logic [1:0] exp_ack;
    exp_ack = 2'b00;
    exp_ack[c] = 1'b1;
    bus_if.req[c]            = 1'b1;
    bus_if.we[c]             = w;
    bus_if.addr[c*12 +: 12]  = a;
    bus_if.wdata[c*12 +: 12] = d;
    step();
    check({tag, " issue busy"}, 32'(bus_if.busy), 32'd1);
    check({tag, " issue mem_addr"}, 32'(bus_if.mem_addr), 32'(a));
    check({tag, " issue mem_wren"}, 32'(bus_if.mem_wren), 32'(w));
    if (w) check({tag, " issue mem_wdata"}, 32'(bus_if.mem_wdata), 32'(d));
    cyc = 1;
    while (bus_if.ack == 2'b00 && cyc < 10) begin
      step();
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd3);
    check({tag, " ack"}, 32'(bus_if.ack), 32'(exp_ack));
    if (chk) check({tag, " rdata"}, 32'(bus_if.rdata), 32'(exp));
    bus_if.req[c] = 1'b0;
    step();
    check({tag, " ack pulse"}, 32'(bus_if.ack), 32'd0);
  endtask

  // Watch both cores for 12 cycles, dropping each req on its ack.
  task automatic watch_pair(output int t0, output int t1,
                            output logic [11:0] r0, output logic [11:0] r1,
                            output int both);
    t0 = 0; t1 = 0; r0 = 12'h000; r1 = 12'h000; both = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      if (bus_if.ack == 2'b11) both++;
      if (bus_if.ack[0]) begin
        t0 = cyc;
        r0 = bus_if.rdata;
        bus_if.req[0] = 1'b0;
      end
      if (bus_if.ack[1]) begin
        t1 = cyc;
        r1 = bus_if.rdata;
        bus_if.req[1] = 1'b0;
      end
    end
  endtask

  initial begin
    int t0, t1, both, n, last_cyc;
    logic [11:0] r0, r1;

    vecs[0] = '{core: 0, we: 1'b1, addr: 12'h010, wdata: 12'hABC, chk: 1'b0, exp: 12'h000};
    vecs[1] = '{core: 0, we: 1'b0, addr: 12'h010, wdata: 12'h000, chk: 1'b1, exp: 12'hABC};
    vecs[2] = '{core: 1, we: 1'b1, addr: 12'hFFF, wdata: 12'h123, chk: 1'b0, exp: 12'h000};
    vecs[3] = '{core: 1, we: 1'b0, addr: 12'hFFF, wdata: 12'h000, chk: 1'b1, exp: 12'h123};
    vecs[4] = '{core: 0, we: 1'b1, addr: 12'h000, wdata: 12'hFED, chk: 1'b0, exp: 12'h000};
    vecs[5] = '{core: 1, we: 1'b0, addr: 12'h000, wdata: 12'h000, chk: 1'b1, exp: 12'hFED};
    vecs[6] = '{core: 0, we: 1'b1, addr: 12'h010, wdata: 12'h111, chk: 1'b0, exp: 12'h000};
    vecs[7] = '{core: 1, we: 1'b1, addr: 12'h020, wdata: 12'h222, chk: 1'b0, exp: 12'h000};

    // Reset held for two cycles with both cores requesting.
    reset        = 1'b1;
    bus_if.req   = 2'b11;
    bus_if.we    = 2'b00;
    bus_if.addr  = {12'h020, 12'h010};
    bus_if.wdata = 24'h000000;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("reset%0d ack", i), 32'(bus_if.ack), 32'd0);
      check($sformatf("reset%0d mem_wren", i), 32'(bus_if.mem_wren), 32'd0);
      check($sformatf("reset%0d busy", i), 32'(bus_if.busy), 32'd0);
      check($sformatf("reset%0d rr_ptr", i), 32'(dut.rr_ptr_r), 32'd0);
    end
    check("reset rdata", 32'(bus_if.rdata), 32'd0);
    check("reset mem_addr", 32'(bus_if.mem_addr), 32'd0);
    check("reset mem_wdata", 32'(bus_if.mem_wdata), 32'd0);
    reset      = 1'b0;
    bus_if.req = 2'b00;
    step();

    // Table of single-core accesses.
    for (int i = 0; i < 8; i++) begin
      single_access($sformatf("vec%0d", i), vecs[i].core, vecs[i].we, vecs[i].addr,
                    vecs[i].wdata, vecs[i].chk, vecs[i].exp);
    end

    // Contention: simultaneous loads, rr_ptr is back at 0.
    bus_if.we   = 2'b00;
    bus_if.addr = {12'h020, 12'h010};
    bus_if.req  = 2'b11;
    watch_pair(t0, t1, r0, r1, both);
    check("contend t0", 32'(t0), 32'd3);
    check("contend rdata0", 32'(r0), 32'h111);
    check("contend t1", 32'(t1), 32'd6);
    check("contend rdata1", 32'(r1), 32'h222);
    check("contend double ack", 32'(both), 32'd0);

    // Fairness: both cores request continuously for 8 accesses.
    n = 0;
    last_cyc = 0;
    bus_if.req = 2'b11;
    for (int cyc = 1; cyc <= 40 && n < 8; cyc++) begin
      step();
      if (bus_if.ack != 2'b00) begin
        check($sformatf("fair ack%0d", n), 32'(bus_if.ack), (n % 2 == 0) ? 32'd1 : 32'd2);
        if (n > 0) check($sformatf("fair gap%0d", n), 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        n++;
        if (n == 8) bus_if.req = 2'b00;
      end
    end
    check("fair count", 32'(n), 32'd8);
    step();
    step();

    // Write collision on 12'h030: core0 then core1, last write wins.
    bus_if.we    = 2'b11;
    bus_if.addr  = {12'h030, 12'h030};
    bus_if.wdata = {12'h777, 12'h555};
    bus_if.req   = 2'b11;
    watch_pair(t0, t1, r0, r1, both);
    check("collide t0", 32'(t0), 32'd3);
    check("collide t1", 32'(t1), 32'd6);
    check("collide double ack", 32'(both), 32'd0);
    bus_if.we = 2'b00;
    single_access("collide load", 0, 1'b0, 12'h030, 12'h000, 1'b1, 12'h777);

    // Reset during ISSUE of a core1 store to 12'h040.
    bus_if.req[1]        = 1'b1;
    bus_if.we[1]         = 1'b1;
    bus_if.addr[23:12]   = 12'h040;
    bus_if.wdata[23:12]  = 12'h0AA;
    step();
    check("abort issue busy", 32'(bus_if.busy), 32'd1);
    check("abort issue mem_wren", 32'(bus_if.mem_wren), 32'd1);
    reset         = 1'b1;
    bus_if.req[1] = 1'b0;
    step();
    check("abort busy", 32'(bus_if.busy), 32'd0);
    check("abort mem_wren", 32'(bus_if.mem_wren), 32'd0);
    check("abort ack", 32'(bus_if.ack), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("abort quiet%0d ack", i), 32'(bus_if.ack), 32'd0);
      check($sformatf("abort quiet%0d busy", i), 32'(bus_if.busy), 32'd0);
    end
    bus_if.we = 2'b00;
    single_access("post-abort load", 1, 1'b0, 12'h040, 12'h000, 1'b1, 12'h0AA);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
